// File: rtl/fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit
//
// Front-end fetch stage. Owns the fetch PC, issues in-order instruction
// memory requests, buffers returned instructions in a small fetch queue and
// hands {pc, inst} pairs to decode. A taken-branch redirect from the branch
// mispredict unit reloads the PC, empties the queue and discards every
// response still in flight from the old path.
//
// Optional feature macro: FETCH_BYPASS_EN
//   When defined, a response arriving while the queue is empty is presented
//   on dec_* in the same cycle and skips the queue if decode takes it.
//
// Ports
//   clk            : single clock, all state on the rising edge
//   resetn         : asynchronous active-low reset
//   redirect_valid : flush from the branch mispredict unit
//   redirect_sel   : next_pc_sel from the branch mispredict unit
//   redirect_pc    : redirect target PC
//   imem_req_valid : fetch request valid
//   imem_req_ready : memory accepts the request
//   imem_req_addr  : current fetch PC
//   imem_rsp_valid : in-order response, no backpressure
//   imem_rsp_inst  : returned instruction word
//   dec_valid      : queue head valid to decode
//   dec_ready      : decode accepts the head
//   dec_pc         : PC of the head instruction
//   dec_inst       : head instruction word
// ----------------------------------------------------------------------------
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    pc_plus_4_t = 2'd0,
    sb          = 2'd1
  } next_pc_t;

endpackage

module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned                INST_ADDR_WIDTH = 32,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter int unsigned                FQ_DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       redirect_valid,
  input  next_pc_t                   redirect_sel,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [INST_ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_inst,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [INST_ADDR_WIDTH-1:0] dec_pc,
  output logic [31:0]                dec_inst
);

  localparam int unsigned CW  = $clog2(FQ_DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned PW  = $clog2(FQ_DEPTH);

  localparam logic [CW:0]                DEPTH_W = CW1'(FQ_DEPTH);
  localparam logic [INST_ADDR_WIDTH-1:0] PC_STEP = INST_ADDR_WIDTH'(4);
  localparam logic [PW-1:0]              PTR_ONE = PW'(1);
  localparam logic [CW-1:0]              CNT_ONE = CW'(1);

  logic [INST_ADDR_WIDTH-1:0] fetchPc_q, fetchPc_d;
  logic [CW-1:0]              occ_q, occ_d;
  logic [CW-1:0]              outstanding_q, outstanding_d;
  logic [CW-1:0]              dropCnt_q, dropCnt_d;
  logic [PW-1:0]              fqRdPtr_q, fqRdPtr_d;
  logic [PW-1:0]              fqWrPtr_q, fqWrPtr_d;
  logic [PW-1:0]              pcRdPtr_q, pcRdPtr_d;
  logic [PW-1:0]              pcWrPtr_q, pcWrPtr_d;

  logic [INST_ADDR_WIDTH-1:0] fqPc_q   [FQ_DEPTH];
  logic [31:0]                fqInst_q [FQ_DEPTH];
  logic [INST_ADDR_WIDTH-1:0] pcFifo_q [FQ_DEPTH];

  logic                       redirectTaken;
  logic [CW:0]                creditUsed;
  logic                       reqFire;
  logic                       rspDrop;
  logic                       rspAccept;
  logic                       bypassSel;
  logic                       fqPush;
  logic                       fqPop;
  logic                       decFire;
  logic [INST_ADDR_WIDTH-1:0] rspPc;

  assign redirectTaken = redirect_valid && (redirect_sel == sb);

  // Every request holds a slot until its instruction leaves the queue, so
  // queue occupancy plus in-flight requests can never exceed the depth.
  // Gating with resetn keeps the request quiet while reset is held.
  assign creditUsed     = {1'b0, occ_q} + {1'b0, outstanding_q};
  assign imem_req_valid = resetn && (creditUsed < DEPTH_W) && !redirectTaken;
  assign imem_req_addr  = fetchPc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // The PC side-FIFO pops on every response, dropped or not, so it stays
  // aligned with the memory's in-order response stream across redirects.
  assign rspPc     = pcFifo_q[pcRdPtr_q];
  assign rspDrop   = redirectTaken || (dropCnt_q != '0);
  assign rspAccept = imem_rsp_valid && !rspDrop;

`ifdef FETCH_BYPASS_EN
  assign bypassSel = resetn && rspAccept && (occ_q == '0);
`else
  assign bypassSel = 1'b0;
`endif

  // Decode-side outputs: queue head first, then the bypassed response when
  // the queue is empty. A redirect blanks decode for the whole cycle.
  always_comb begin
    dec_valid = 1'b0;
    dec_pc    = '0;
    dec_inst  = '0;
    if (!redirectTaken) begin
      if (occ_q != '0) begin
        dec_valid = 1'b1;
        dec_pc    = fqPc_q[fqRdPtr_q];
        dec_inst  = fqInst_q[fqRdPtr_q];
      end else if (bypassSel) begin
        dec_valid = 1'b1;
        dec_pc    = rspPc;
        dec_inst  = imem_rsp_inst;
      end
    end
  end

  assign decFire = dec_valid && dec_ready;
  assign fqPop   = decFire && (occ_q != '0);
  assign fqPush  = rspAccept && !(bypassSel && dec_ready);

  // Next-state logic for the PC, the counters and the queue pointers.
  always_comb begin
    fetchPc_d     = fetchPc_q;
    occ_d         = occ_q;
    outstanding_d = outstanding_q;
    dropCnt_d     = dropCnt_q;
    fqRdPtr_d     = fqRdPtr_q;
    fqWrPtr_d     = fqWrPtr_q;
    pcRdPtr_d     = pcRdPtr_q;
    pcWrPtr_d     = pcWrPtr_q;

    if (redirectTaken) begin
      fetchPc_d = redirect_pc;
    end else if (reqFire) begin
      fetchPc_d = fetchPc_q + PC_STEP;
    end

    outstanding_d = outstanding_q + CW'(reqFire) - CW'(imem_rsp_valid);

    if (reqFire) begin
      pcWrPtr_d = pcWrPtr_q + PTR_ONE;
    end
    if (imem_rsp_valid) begin
      pcRdPtr_d = pcRdPtr_q + PTR_ONE;
    end

    // Everything still in flight at a redirect belongs to the old path,
    // except a response landing in the redirect cycle itself, which is
    // discarded right here rather than counted.
    if (redirectTaken) begin
      dropCnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (dropCnt_q != '0)) begin
      dropCnt_d = dropCnt_q - CNT_ONE;
    end

    if (redirectTaken) begin
      occ_d     = '0;
      fqRdPtr_d = '0;
      fqWrPtr_d = '0;
    end else begin
      if (fqPush) begin
        fqWrPtr_d = fqWrPtr_q + PTR_ONE;
      end
      if (fqPop) begin
        fqRdPtr_d = fqRdPtr_q + PTR_ONE;
      end
      occ_d = occ_q + CW'(fqPush) - CW'(fqPop);
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetchPc_q     <= RESET_PC;
      occ_q         <= '0;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
      fqRdPtr_q     <= '0;
      fqWrPtr_q     <= '0;
      pcRdPtr_q     <= '0;
      pcWrPtr_q     <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      occ_q         <= occ_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
      fqRdPtr_q     <= fqRdPtr_d;
      fqWrPtr_q     <= fqWrPtr_d;
      pcRdPtr_q     <= pcRdPtr_d;
      pcWrPtr_q     <= pcWrPtr_d;
    end
  end

  // Storage arrays need no reset: occupancy and pointers decide what is
  // visible, and decode outputs are forced to zero when nothing is valid.
  always_ff @(posedge clk) begin
    if (reqFire) begin
      pcFifo_q[pcWrPtr_q] <= fetchPc_q;
    end
    if (fqPush) begin
      fqPc_q[fqWrPtr_q]   <= rspPc;
      fqInst_q[fqWrPtr_q] <= imem_rsp_inst;
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Front-end fetch stage directly downstream of the branch mispredict unit: owns the architectural fetch PC, issues in-order instruction-memory requests, buffers returned instructions in a small fetch queue, and hands {pc, inst} pairs to decode. A taken-branch redirect (`flush` with `next_pc_sel == sb`) reloads the PC, empties the queue and discards every response still in flight from the old path.

## Interface
- `RESET_PC`, default 0 — PC value loaded on reset; width `INST_ADDR_WIDTH`.
- `FQ_DEPTH`, default 4 — fetch-queue entries and credit limit; power of two, ≥2.
- `clk` in 1 — single clock; all state on rising edge.
- `resetn` in 1 — one clock; reset is asynchronous and active-low.
- `redirect_valid` in 1 — `flush` from branch mispredict unit.
- `redirect_sel` in `next_pc_t` — `next_pc_sel` from branch mispredict unit.
- `redirect_pc` in `INST_ADDR_WIDTH` — target PC; don't-care unless redirect taken.
- `imem_req_valid` out 1 — fetch request valid.
- `imem_req_ready` in 1 — memory accepts request.
- `imem_req_addr` out `INST_ADDR_WIDTH` — current fetch PC.
- `imem_rsp_valid` in 1 — in-order response, no backpressure.
- `imem_rsp_inst` in 32 — returned instruction word.
- `dec_valid` out 1 — queue head valid to decode.
- `dec_ready` in 1 — decode accepts head.
- `dec_pc` out `INST_ADDR_WIDTH` — PC of head instruction.
- `dec_inst` out 32 — head instruction.

## Operation
- Redirect taken iff `redirect_valid && redirect_sel == sb`; any other combination is ignored.
- State: `fetch_pc`, queue (FQ_DEPTH × {pc, inst}, rd/wr pointers, `occ`), `outstanding` and `drop_cnt` counters, all `$clog2(FQ_DEPTH+1)` bits wide.
- Request: `imem_req_valid = (occ + outstanding < FQ_DEPTH) && !redirect_taken`. On handshake, `fetch_pc <= fetch_pc + 4` (wraps modulo 2^`INST_ADDR_WIDTH`), `outstanding` increments.
- Each response decrements `outstanding`. If `drop_cnt > 0`, response is discarded and `drop_cnt` decrements; otherwise it is written to the queue tail with the PC captured at request issue. A PC side-FIFO of depth FQ_DEPTH, written on request handshake and popped on response, supplies that PC.
- Decode handshake (`dec_valid && dec_ready`) pops the head.
- Redirect cycle: `fetch_pc <= redirect_pc`; queue cleared (`occ <= 0`); `dec_valid` forced 0; `drop_cnt <= outstanding - imem_rsp_valid`. A response arriving in the redirect cycle is discarded.
- Credit rule guarantees queue never overflows; no response is ever lost for lack of space.
- Simultaneous push and pop on a full queue is legal; `occ` is unchanged.

## Timing
- Reset (async assert): `fetch_pc = RESET_PC`, `occ = outstanding = drop_cnt = 0`, `imem_req_valid = 0`, `dec_valid = 0`, `dec_pc`/`dec_inst = 0`.
- First request with `imem_req_addr = RESET_PC` in the first cycle after `resetn` deasserts.
- Fetch-to-decode latency without bypass: response in cycle N → `dec_valid` in N+1.
- Redirect in cycle N → request to `redirect_pc` in N+1; `dec_valid` low in N and stays low until first new-path response is queued.
- Reset mid-operation discards everything; in-flight memory responses after reset are the environment's responsibility.
- Sustained throughput: one instruction per cycle with 1-cycle memory and `dec_ready` high.

## Configuration
- `FETCH_BYPASS_EN` defined: when queue is empty, a non-dropped response with `dec_ready` high is presented combinationally on `dec_*` in the same cycle and not written to the queue (0-cycle latency); if `dec_ready` is low, it is written to the queue as normal.
- Undefined: every response goes through the queue; minimum latency 1 cycle.

## Test plan
- Reset with `RESET_PC=0x100`, 1-cycle memory, `dec_ready=1` → decode sees PCs 0x100, 0x104, 0x108… one per cycle from cycle 2 (cycle 1 with `FETCH_BYPASS_EN`).
- `dec_ready=0` for 10 cycles → exactly FQ_DEPTH requests issued, `imem_req_valid` low, queue full; release → in-order drain, no gaps or duplicates.
- 3-cycle memory latency, redirect to 0x400 with 2 responses outstanding → both discarded, next `dec_pc = 0x400`.
- Redirect in the same cycle as `imem_rsp_valid` and `dec_ready` → response dropped, no decode handshake, `drop_cnt` correct.
- `redirect_valid=1` with `redirect_sel=pc_plus_4_t` → no effect on PC, queue or outputs.
- Assert `resetn` low mid-stream with full queue → all outputs at reset values immediately; refetch from `RESET_PC`.
